// File: rtl/plot_sink_pkg.sv
// Shared definitions for the pixel-plot sink: screen geometry, colour names,
// the plot command record carried through the FIFO, and the controller states.
package plot_sink_pkg;

    localparam logic [7:0]  SCREEN_WIDTH  = 8'd160;
    localparam logic [6:0]  SCREEN_HEIGHT = 7'd120;
    localparam int          ADDR_W        = 15;
    localparam logic [14:0] FB_WORDS      = 15'd19200;
    localparam logic [14:0] FB_LAST       = FB_WORDS - 15'd1;

    // Colours are {R,G,B}, one bit per channel
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

    localparam int CMD_W = 18;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } plot_cmd_t;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Row-major framebuffer word address; operands widened first so the
    // product cannot wrap inside a narrower intermediate
    function automatic logic [14:0] pixel_addr(input logic [7:0] px, input logic [6:0] py);
        logic [14:0] row_base;
        row_base = 15'(py) * 15'(SCREEN_WIDTH);
        return row_base + 15'(px);
    endfunction

endpackage

// File: rtl/plot_sink_fifo.sv
// Small synchronous FIFO holding accepted on-screen plot commands between the
// drawing side and the framebuffer write register.
module plot_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 18
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] storage [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = storage[rd_ptr[PTR_W-1:0]];

    // Pointer bookkeeping; a reset simply forgets whatever was queued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // Entry storage needs no reset since the pointers gate every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            storage[wr_ptr[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/plot_sink.sv
// Receiving end of the pixel-plot interface: bounds-checks plot commands,
// queues on-screen ones and writes them into the 3-bit framebuffer, and
// sweeps the whole screen to a fixed colour after reset or on request.
module plot_sink
    import plot_sink_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [2:0] CLEAR_COLOUR = BLACK
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  colour,
    input  logic        plot,
    output logic        ready,
    input  logic        clear,
    output logic        busy,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_wren,
    input  logic        mem_ready,
    output logic        dropped,
    output logic        overflow
);

    state_t            state;
    plot_cmd_t         in_cmd;
    plot_cmd_t         head_cmd;
    logic [CMD_W-1:0]  fifo_din;
    logic [CMD_W-1:0]  fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic              on_screen;
    logic              accept;
    logic              push;
    logic              pop;
    logic              wr_done;
    logic              reg_free;

    assign in_cmd.x      = x;
    assign in_cmd.y      = y;
    assign in_cmd.colour = colour;
    assign fifo_din      = in_cmd;
    assign head_cmd      = plot_cmd_t'(fifo_dout);

    // Handshake and pipeline control; a raised clear closes the door the same
    // cycle so nothing new slips in behind the drain
    assign on_screen = (x < SCREEN_WIDTH) && (y < SCREEN_HEIGHT);
    assign ready     = (state == RUN) && !fifo_full && !clear;
    assign busy      = (state != RUN);
    assign accept    = plot && ready;
    assign push      = accept && on_screen;
    assign wr_done   = mem_wren && mem_ready;
    assign reg_free  = !mem_wren || wr_done;
    assign pop       = ((state == RUN) || (state == DRAIN)) && reg_free && !fifo_empty;

    plot_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (CMD_W)
    ) u_fifo (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Controller and framebuffer write register; mem_addr doubles as the
    // sweep counter while clearing
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state    <= CLEAR;
            mem_wren <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            dropped  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            dropped <= accept && !on_screen;
            if (plot && !ready) begin
                overflow <= 1'b1;
            end

            case (state)
                CLEAR: begin
                    if (!mem_wren) begin
                        mem_wren <= 1'b1;
                        mem_addr <= '0;
                        mem_data <= CLEAR_COLOUR;
                    end else if (mem_ready) begin
                        if (mem_addr == FB_LAST) begin
                            state    <= RUN;
                            mem_wren <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 15'd1;
                        end
                    end
                end

                RUN, DRAIN: begin
                    if (pop) begin
                        mem_wren <= 1'b1;
                        mem_addr <= pixel_addr(head_cmd.x, head_cmd.y);
                        mem_data <= head_cmd.colour;
                    end else if (wr_done) begin
                        mem_wren <= 1'b0;
                    end

                    if ((state == RUN) && clear) begin
                        state <= DRAIN;
                    end else if ((state == DRAIN) && fifo_empty && reg_free) begin
                        state    <= CLEAR;
                        mem_wren <= 1'b1;
                        mem_addr <= '0;
                        mem_data <= CLEAR_COLOUR;
                    end
                end

                default: begin
                    state    <= CLEAR;
                    mem_wren <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plot_sink.sv
// Self-checking bench for plot_sink: a reference model predicts every
// framebuffer write into a queue and a monitor pops and compares each write
// the DUT actually hands over.
module tb_plot_sink;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int FB_SIZE  = SCREEN_W * SCREEN_H;
    localparam int C_RED    = 4;
    localparam int C_GREEN  = 2;
    localparam int C_WHITE  = 7;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic [7:0]  x        = '0;
    logic [6:0]  y        = '0;
    logic [2:0]  colour   = '0;
    logic        plot     = 1'b0;
    logic        clear    = 1'b0;
    logic        mem_ready = 1'b1;
    logic        ready;
    logic        busy;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_wren;
    logic        dropped;
    logic        overflow;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    plot_sink dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .ready     (ready),
        .clear     (clear),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .mem_ready (mem_ready),
        .dropped   (dropped),
        .overflow  (overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, "_ready"},    32'(ready),    0);
        check_output({tag, "_busy"},     32'(busy),     1);
        check_output({tag, "_mem_wren"}, 32'(mem_wren), 0);
        check_output({tag, "_mem_addr"}, 32'(mem_addr), 0);
        check_output({tag, "_mem_data"}, 32'(mem_data), 0);
        check_output({tag, "_dropped"},  32'(dropped),  0);
        check_output({tag, "_overflow"}, 32'(overflow), 0);
    endtask

    // A full clear is 19200 writes of colour 0 in address order
    task automatic push_sweep();
        for (int i = 0; i < FB_SIZE; i++) begin
            exp_q.push_back('{addr: i, data: 0});
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // One cycle of plot-side stimulus; the model decides what the accepted
    // command should produce and the dropped pulse is checked after the edge
    task automatic apply_stimulus(input logic p, input int px, input int py, input int pc,
                                  output logic taken);
        logic drop_exp;
        plot   = p;
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(pc);
        #1;
        taken    = p && ready;
        drop_exp = 1'b0;
        if (taken) begin
            if (px < SCREEN_W && py < SCREEN_H) begin
                exp_q.push_back('{addr: py * SCREEN_W + px, data: pc});
            end else begin
                drop_exp = 1'b1;
            end
        end
        tick();
        check_output("dropped_pulse", 32'(dropped), 32'(drop_exp));
        plot = 1'b0;
    endtask

    // Bounded wait for the sink to go quiet with every predicted write seen
    task automatic wait_idle(input int limit, input string tag);
        logic done;
        done = 1'b0;
        for (int c = 0; c < limit && !done; c++) begin
            if (!busy && !mem_wren && exp_q.size() == 0) begin
                done = 1'b1;
            end else begin
                tick();
            end
        end
        check_output({tag, "_idle_timeout"}, 32'(done), 1);
    endtask

    // Monitor: every write the framebuffer accepts must be the next predicted one
    always @(negedge CLOCK_50) begin
        wr_t e;
        if (resetn && mem_wren && mem_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: actual addr=%0d data=%0d required none", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                check_output("write_addr", 32'(mem_addr), 32'(e.addr));
                check_output("write_data", 32'(mem_data), 32'(e.data));
            end
        end
    end

    initial begin
        logic taken;
        logic found;
        int   viol;

        // Power-on reset and the initial full-screen sweep
        repeat (3) @(posedge CLOCK_50);
        #1;
        check_reset("por");
        push_sweep();
        resetn = 1'b1;
        wait_idle(FB_SIZE + 100, "initial_sweep");
        check_output("ready_after_sweep", 32'(ready), 1);
        check_output("busy_after_sweep", 32'(busy), 0);

        // Single plot latency: write appears two edges after the plot
        apply_stimulus(1'b1, 80, 60, 6, taken);
        check_output("lat_taken", 32'(taken), 1);
        check_output("lat_wren_edge_k", 32'(mem_wren), 0);
        apply_stimulus(1'b0, 0, 0, 0, taken);
        check_output("lat_wren", 32'(mem_wren), 1);
        check_output("lat_addr", 32'(mem_addr), 9680);
        check_output("lat_data", 32'(mem_data), 6);
        apply_stimulus(1'b0, 0, 0, 0, taken);
        check_output("lat_wren_after", 32'(mem_wren), 0);

        // Screen-edge and off-screen plots
        apply_stimulus(1'b1, 159, 119, 7, taken);
        apply_stimulus(1'b1, 160, 5, 1, taken);
        apply_stimulus(1'b1, 0, 120, 1, taken);
        apply_stimulus(1'b0, 0, 0, 0, taken);
        wait_idle(50, "bounds");

        // Back-pressure: register plus four FIFO entries, then overflow
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, i, 0, C_WHITE, taken);
            check_output("fill_taken", 32'(taken), 1);
        end
        check_output("overflow_before", 32'(overflow), 0);
        apply_stimulus(1'b1, 5, 0, C_WHITE, taken);
        check_output("ready_when_full", 32'(taken), 0);
        check_output("overflow_set", 32'(overflow), 1);
        check_output("held_wren", 32'(mem_wren), 1);
        check_output("held_addr", 32'(mem_addr), 0);
        mem_ready = 1'b1;
        wait_idle(50, "backpressure");

        // Randomised plots with random framebuffer back-pressure
        for (int n = 0; n < 400; n++) begin
            mem_ready = ($urandom_range(0, 3) != 0);
            apply_stimulus(($urandom_range(0, 2) != 0), int'($urandom_range(0, 175)),
                           int'($urandom_range(0, 127)), int'($urandom_range(0, 7)), taken);
        end
        mem_ready = 1'b1;
        apply_stimulus(1'b0, 0, 0, 0, taken);
        wait_idle(100, "random");

        // Clear request with two commands still queued
        mem_ready = 1'b0;
        apply_stimulus(1'b1, 10, 10, C_RED, taken);
        check_output("preclear_taken_a", 32'(taken), 1);
        apply_stimulus(1'b1, 20, 20, C_GREEN, taken);
        check_output("preclear_taken_b", 32'(taken), 1);
        clear = 1'b1;
        #1;
        check_output("ready_on_clear", 32'(ready), 0);
        push_sweep();
        tick();
        mem_ready = 1'b1;
        viol  = 0;
        found = 1'b0;
        for (int c = 0; c < 6000 && !found; c++) begin
            if (ready !== 1'b0 || busy !== 1'b1) begin
                viol++;
            end
            if (c == 3) begin
                clear = 1'b0;
            end
            if (exp_q.size() == FB_SIZE - 5000) begin
                found = 1'b1;
            end else begin
                tick();
            end
        end
        clear = 1'b0;
        check_output("reached_addr_5000", 32'(found), 1);
        check_output("clear_ready0_busy1", 32'(viol), 0);
        check_output("sweep_wren_5000", 32'(mem_wren), 1);
        check_output("sweep_addr_5000", 32'(mem_addr), 5000);

        // Asynchronous reset in the middle of the sweep
        resetn = 1'b0;
        #1;
        check_reset("mid_sweep");
        exp_q.delete();
        push_sweep();
        tick();
        tick();
        resetn = 1'b1;
        wait_idle(FB_SIZE + 100, "restart_sweep");
        check_output("final_ready", 32'(ready), 1);
        check_output("final_busy", 32'(busy), 0);
        check_output("final_overflow", 32'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/plot_sink.md
Name: plot_sink

Overview:
- Receiving end of the pixel-plot interface (x, y, colour, plot) driven by the shape-drawing FSMs.
- Accepts plot commands and bounds-checks them against the 160x120 screen.
- Buffers accepted commands in a small FIFO and writes them into a 3-bit-per-pixel framebuffer RAM through a valid/ready write port.
- Performs a full-screen clear after reset and on request. Sits between the drawing FSMs and the framebuffer/scanout logic.

Parameters:
SCREEN_WIDTH, 160, pixels per row
SCREEN_HEIGHT, 120, rows
FIFO_DEPTH, 4, plot command buffer entries (power of two, >=2)
CLEAR_COLOUR, 3'b000, colour written during clear sweep

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
x  input  8  plot column
y  input  7  plot row
colour  input  3  plot colour {R,G,B}
plot  input  1  plot request, sampled every edge
ready  output  1  plot accepted on an edge where plot&&ready
clear  input  1  request full-screen clear (level, sampled)
busy  output  1  clear pending or in progress
mem_addr  output  15  framebuffer word address = y*SCREEN_WIDTH + x
mem_data  output  3  framebuffer write data
mem_wren  output  1  write valid
mem_ready  input  1  framebuffer accepts write on edge where mem_wren&&mem_ready
dropped  output  1  one-cycle pulse: accepted plot was off-screen
overflow  output  1  sticky: plot asserted while ready=0

Behaviour:
- Reset (async, resetn=0):
  - FIFO emptied, state=CLEAR, clear counter=0.
  - Outputs: ready=0, busy=1, mem_wren=0, mem_addr=0, mem_data=0, dropped=0, overflow=0.
- States: CLEAR, RUN, DRAIN.
- CLEAR:
  - mem_wren=1, mem_data=CLEAR_COLOUR, mem_addr counts 0..19199.
  - Advances only on edges with mem_ready=1.
  - On the accepted write of 19199: next state RUN, busy=0.
  - ready=0 throughout; clear input ignored.
- RUN:
  - ready = !fifo_full && !clear.
  - Accepted plot with x<SCREEN_WIDTH and y<SCREEN_HEIGHT: pushed into FIFO.
  - Accepted plot with x>=160 or y>=120: not pushed; dropped=1 for the next cycle only.
  - Write register: when empty, or when its write completes this edge, and the FIFO is non-empty, pop the head into the register. This loads mem_addr=y*160+x (15-bit unsigned; width-extend before multiply), mem_data=colour, mem_wren=1.
  - mem_wren stays high with addr/data stable until an edge with mem_ready=1.
  - Latency with FIFO empty and mem_ready=1: plot sampled at edge k, mem_wren high in the cycle after edge k+1. Throughput is one write per cycle.
- Simultaneous push and pop on the same edge are allowed.
  - Full FIFO: ready=0, so no push.
  - Empty FIFO: a push is not popped on the same edge (no bypass).
- clear=1 seen in RUN: next state DRAIN, busy=1, ready=0.
- DRAIN: completes all FIFO entries and the write register, then enters CLEAR with counter=0.
- overflow: set on any edge with plot=1 && ready=0, including during CLEAR and DRAIN. Cleared only by reset.
- Reset mid-clear or mid-drain: pending writes are discarded and the clear sweep restarts from address 0.

Decomposition:
- Shared package:
  - SCREEN_WIDTH/SCREEN_HEIGHT constants.
  - Colour constants BLACK, BLUE, GREEN, YELLOW, RED, WHITE.
  - Plot command struct {x[7:0], y[6:0], colour[2:0]}.
  - State enum {CLEAR, RUN, DRAIN}.
  - FB_WORDS=19200.
- Sub-module plot_fifo: synchronous FIFO with push, pop, full, empty and 18-bit data, parameterised by FIFO_DEPTH, same clock and async reset.

Test Plan:
- Reset release, mem_ready=1 -> mem_wren=1 for exactly 19200 consecutive cycles, addr 0..19199, data 000. Then busy=0 and ready=1.
- After clear, plot (80,60,3'b110) for one cycle -> two edges later mem_wren=1, mem_addr=9680, mem_data=110 for one cycle.
- Plot (159,119,111), then (160,5,001), then (0,120,001) -> one write at addr 19199. Two dropped pulses, no other writes.
- mem_ready=0, 5 consecutive plots (0,0)..(4,0):
  - Register holds (0,0); 4 entries fill the FIFO.
  - ready falls on the cycle after the 5th accept.
  - A 6th plot sets overflow.
  - Raising mem_ready then yields addrs 0,1,2,3,4 in order.
- clear=1 with 2 entries queued -> both queued writes complete first, then a full 19200-write sweep with data 000. ready=0 and busy=1 throughout.
- resetn pulsed low at sweep address 5000 -> outputs at reset values immediately (async). Sweep restarts at addr 0 after release.
